// File: rtl/trace_mon_pkg.sv
// trace_mon_pkg: shared types for the run-control / writeback trace monitor.
//   tm_state_e  - run-control states
//   trace_rec_t - one trace record {pc, rd, data} at the default 32-bit PC width
//   rec_width() - packed record width for an arbitrary PC width
package trace_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt,
        StTimeout
    } tm_state_e;

    localparam int unsigned TraceRecPcW = 32;

    typedef struct packed {
        logic [TraceRecPcW-1:0] pc;
        logic [4:0]             rd;
        logic [31:0]            data;
    } trace_rec_t;

    // pc + 5-bit rd + 32-bit data
    function automatic int unsigned rec_width(input int unsigned pc_w);
        return pc_w + 37;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// trace_ring: DEPTH-entry circular trace buffer with a registered read port.
//   clk, rst       - clock, async active-high reset
//   clr            - synchronous flush: pointers, count and overflow to 0
//   wr_en, wr_data - push one record
//   rd_en          - pop one record; rd_valid/rd_data follow one cycle later
//   count          - entries held
//   overflow       - sticky; a record was dropped (WRAP=0) or overwritten (WRAP=1)
module trace_ring #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 64,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d, rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full, pop, push, grow;

    always_comb begin
        full = (count_q == (AW+1)'(DEPTH));
        // a flush takes priority over a pop in the same cycle
        pop  = rd_en && (count_q != '0) && !clr;
        // when full, a write lands only if a pop frees a slot or wrapping is enabled
        push = wr_en && !clr && (!full || pop || WRAP);
        grow = push && (!full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = pop;
        rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_en && full && !pop) begin
                overflow_d = 1'b1;
                // wrapping write lands on the oldest slot, so the oldest is consumed
                if (WRAP) rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (grow && !pop)      count_d = count_q + (AW+1)'(1);
            else if (!grow && pop) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: run sequencing, halt-PC detection, cycle budget and writeback trace.
//   clk, rst                     - clock, async active-high reset
//   start                        - begin a run (ignored while running)
//   if_valid, if_pc              - IF stage; a valid fetch of HALT_PC ends the run
//   wb_valid, wb_regwrite,
//   wb_pc, wb_rd, wb_data        - WB stage; register writes (rd != 0) are traced
//   rd_en, rd_valid, rd_data     - trace drain port, rd_data = {pc, rd, data}
//   count, overflow              - trace occupancy and sticky loss flag
//   running, halted, timed_out   - run state flags
//   cycle_cnt                    - cycles spent in the current run
//   retire_cnt, bubble_cnt       - perf counters, present only with TRACE_MON_PERF_EN
// Build option: define TRACE_MON_PERF_EN to include the performance counters.
module trace_monitor
    import trace_mon_pkg::*;
#(
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     DEPTH      = 64,
    parameter int unsigned     MAX_CYCLES = 1000,
    parameter logic [PC_W-1:0] HALT_PC    = PC_W'(32'h314),
    parameter bit              WRAP       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       if_valid,
    input  logic [PC_W-1:0]            if_pc,
    input  logic                       wb_valid,
    input  logic                       wb_regwrite,
    input  logic [PC_W-1:0]            wb_pc,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [rec_width(PC_W)-1:0] rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       running,
    output logic                       halted,
    output logic                       timed_out,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                retire_cnt,
    output logic [31:0]                bubble_cnt
);
    localparam int unsigned RecW = rec_width(PC_W);

    tm_state_e   state_q, state_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        start_run, halt_hit, capture;

    always_comb begin
        start_run = start && (state_q != StRun);
        halt_hit  = (state_q == StRun) && if_valid && (if_pc == HALT_PC);
        capture   = (state_q == StRun) && wb_valid && wb_regwrite && (wb_rd != 5'd0);

        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            StRun: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
                // halt has priority over the budget expiring in the same cycle
                if (halt_hit) begin
                    state_d = StHalt;
                end else if (cycle_cnt_q == 32'(MAX_CYCLES - 1)) begin
                    state_d = StTimeout;
                end
            end
            default: begin
                if (start) begin
                    state_d     = StRun;
                    cycle_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

`ifdef TRACE_MON_PERF_EN
    logic [31:0] retire_cnt_q, retire_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (start_run) begin
            retire_cnt_d = '0;
            bubble_cnt_d = '0;
        end else if (state_q == StRun) begin
            if (wb_valid && (retire_cnt_q != '1))  retire_cnt_d = retire_cnt_q + 32'd1;
            if (!if_valid && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign retire_cnt = '0;
    assign bubble_cnt = '0;
`endif

    trace_ring #(
        .WIDTH (RecW),
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_run),
        .wr_en    (capture),
        .wr_data  ({wb_pc, wb_rd, wb_data}),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    assign running   = (state_q == StRun);
    assign halted    = (state_q == StHalt);
    assign timed_out = (state_q == StTimeout);
    assign cycle_cnt = cycle_cnt_q;

endmodule
